// File: rtl/pulse_timestamp_fifo.sv
// Pulse timestamp FIFO: stamps each rising edge of pulse_in with a free-running
// timestamp and buffers the stamps in a show-ahead FIFO drained by rd_en.
// Overflowing events are dropped, flagged (sticky) and counted (saturating).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        timestamp counter enable
//   pulse_in  event input, may stay high for several cycles (one event per rise)
//   rd_en     pop request, ignored while rd_valid=0
//   clr_ovf   clears overflow and drop_cnt (a same-cycle drop wins)
//   rd_data   head-of-FIFO stamp, 0 when empty
//   rd_valid  FIFO not empty
//   level     number of stored entries
//   full      level == DEPTH
//   overflow  sticky drop flag
//   drop_cnt  saturating dropped-event count
module pulse_timestamp_fifo #(
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     pulse_in,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic [TS_W-1:0]          rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [TS_W-1:0]   ts;
    logic              pulse_q;
    logic [TS_W-1:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic              ev;
    logic              pop;
    logic              push;
    logic              drop;
    logic [LW-1:0]     level_after_pop;
    logic [LW-1:0]     level_nxt;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [TS_W-1:0]   head_nxt;
    logic [DROP_W-1:0] drop_cnt_nxt;
    logic              overflow_nxt;

    // Event detect, push/pop/drop decisions and the next show-ahead head value
    always_comb begin
        ev              = pulse_in & ~pulse_q;
        pop             = rd_en & rd_valid;
        // A pop frees the slot in the same edge, so full+pop still accepts the write
        push            = ev & (~full | pop);
        drop            = ev & full & ~pop;
        level_after_pop = level - LW'(pop);
        level_nxt       = level_after_pop + LW'(push);
        rd_ptr_nxt      = pop ? rd_ptr + AW'(1) : rd_ptr;

        head_nxt = '0;
        if (level_nxt != '0) begin
            // The new stamp becomes the head only if nothing older survives the pop
            if (push && (level_after_pop == '0)) begin
                head_nxt = ts;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end

        overflow_nxt = overflow;
        drop_cnt_nxt = drop_cnt;
        if (drop) begin
            overflow_nxt = 1'b1;
            if (clr_ovf) begin
                drop_cnt_nxt = DROP_W'(1);
            end else if (drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt_nxt = drop_cnt + DROP_W'(1);
            end
        end else if (clr_ovf) begin
            overflow_nxt = 1'b0;
            drop_cnt_nxt = '0;
        end
    end

    // Storage array; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= ts;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            pulse_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
            rd_data  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (en) begin
                ts <= ts + TS_W'(1);
            end
            pulse_q  <= pulse_in;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            rd_valid <= (level_nxt != '0);
            full     <= (level_nxt == LW'(DEPTH));
            rd_data  <= head_nxt;
            overflow <= overflow_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_timestamp_fifo.sv
// Self-checking bench for pulse_timestamp_fifo: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_pulse_timestamp_fifo;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        pulse_in = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [2:0]  level;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (value as seen during the current cycle)
    logic [15:0] m_ts = '0;
    logic        m_pq = 1'b0;
    logic [15:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic [7:0]  m_drop = '0;

    pulse_timestamp_fifo #(.TS_W(16), .DEPTH(DEPTH), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .pulse_in(pulse_in), .rd_en(rd_en),
        .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
        .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Apply the current inputs to the model, then let the DUT take the same edge
    task automatic tick();
        logic ev, pop, drp;
        if (rst) begin
            m_ts = '0; m_pq = 1'b0; m_q.delete(); m_ovf = 1'b0; m_drop = '0;
        end else begin
            ev  = pulse_in && !m_pq;
            pop = rd_en && (m_q.size() > 0);
            drp = ev && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (ev && !drp) m_q.push_back(m_ts);
            if (drp) begin
                m_ovf  = 1'b1;
                m_drop = clr_ovf ? 8'd1 : ((m_drop == 8'hff) ? m_drop : m_drop + 8'd1);
            end else if (clr_ovf) begin
                m_ovf = 1'b0; m_drop = '0;
            end
            m_pq = pulse_in;
            if (en) m_ts = m_ts + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic advance_to(input logic [15:0] t);
        int guard = 0;
        while (m_ts != t && guard < 70000) begin
            tick(); guard++;
        end
        n_vec++;
        if (m_ts != t) begin
            n_err++; $display("FAIL advance_to: ts=%0d required=%0d", m_ts, t);
        end
    endtask

    task automatic pulse_at(input logic [15:0] t);
        advance_to(t);
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; pulse_in = 1'b1; rd_en = 1'b1; clr_ovf = 1'b1;
        do_reset();
        pulse_in = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_vec++; if (rd_data !== 16'd0) begin n_err++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
        n_vec++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL reset_ovf: got ovf=%b drop=%0d want 0/0", overflow, drop_cnt); end
    endtask

    task automatic test_single();
        do_reset(); en = 1'b1;
        pulse_at(16'd5);
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 16'd5 || level !== 3'd1) begin
            n_err++; $display("FAIL single_write: got v=%b d=%0d l=%0d want 1/5/1", rd_valid, rd_data, level); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 16'd0 || level !== 3'd0) begin
            n_err++; $display("FAIL single_read: got v=%b d=%0d l=%0d want 0/0/0", rd_valid, rd_data, level); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++; if (rd_valid !== 1'b0 || level !== 3'd0 || rd_data !== 16'd0) begin
            n_err++; $display("FAIL read_empty: got v=%b d=%0d l=%0d want 0/0/0", rd_valid, rd_data, level); end
    endtask

    task automatic test_held();
        do_reset(); en = 1'b1;
        advance_to(16'd20);
        pulse_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        pulse_in = 1'b0; tick();
        n_vec++; if (level !== 3'd1 || rd_data !== 16'd20) begin
            n_err++; $display("FAIL held_pulse: got l=%0d d=%0d want 1/20", level, rd_data); end
    endtask

    task automatic test_overflow();
        logic [15:0] exp;
        do_reset(); en = 1'b1;
        for (int i = 0; i < 6; i++) pulse_at(16'(10 + 2 * i));
        n_vec++; if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            n_err++; $display("FAIL overflow_state: got l=%0d f=%b o=%b dc=%0d want 4/1/1/2",
                              level, full, overflow, drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            exp = 16'(10 + 2 * i);
            n_vec++; if (rd_data !== exp || rd_valid !== 1'b1) begin
                n_err++; $display("FAIL overflow_drain%0d: got d=%0d v=%b want %0d/1", i, rd_data, rd_valid, exp); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        n_vec++; if (level !== 3'd0 || full !== 1'b0) begin
            n_err++; $display("FAIL overflow_empty: got l=%0d f=%b want 0/0", level, full); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4];
        logic [15:0] t;
        exp[0] = 16'd12; exp[1] = 16'd14; exp[2] = 16'd16; exp[3] = 16'd30;
        do_reset(); en = 1'b1;
        for (int i = 0; i < 4; i++) pulse_at(16'(10 + 2 * i));
        advance_to(16'd30);
        pulse_in = 1'b1; rd_en = 1'b1; tick(); pulse_in = 1'b0; rd_en = 1'b0;
        n_vec++; if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL full_push_pop: got l=%0d f=%b o=%b dc=%0d want 4/1/0/0",
                              level, full, overflow, drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (rd_data !== exp[i]) begin
                n_err++; $display("FAIL full_pop_drain%0d: got %0d want %0d", i, rd_data, exp[i]); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        t = m_ts;
        pulse_in = 1'b1; rd_en = 1'b1; tick(); pulse_in = 1'b0; rd_en = 1'b0;
        n_vec++; if (level !== 3'd1 || rd_valid !== 1'b1 || rd_data !== t) begin
            n_err++; $display("FAIL empty_push_pop: got l=%0d v=%b d=%0d want 1/1/%0d", level, rd_valid, rd_data, t); end
    endtask

    task automatic test_wrap();
        logic [15:0] t;
        do_reset(); en = 1'b1;
        pulse_at(16'd65535);
        pulse_at(16'd1);
        n_vec++; if (rd_data !== 16'd65535 || level !== 3'd2) begin
            n_err++; $display("FAIL wrap_first: got d=%0d l=%0d want 65535/2", rd_data, level); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++; if (rd_data !== 16'd1) begin
            n_err++; $display("FAIL wrap_second: got %0d want 1", rd_data); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        en = 1'b0; t = m_ts;
        for (int i = 0; i < 5; i++) tick();
        pulse_in = 1'b1; tick(); pulse_in = 1'b0; tick(); tick();
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        n_vec++; if (rd_data !== t || level !== 3'd2) begin
            n_err++; $display("FAIL frozen_ts: got d=%0d l=%0d want %0d/2", rd_data, level, t); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_vec++; if (rd_data !== t) begin
            n_err++; $display("FAIL frozen_ts2: got %0d want %0d", rd_data, t); end
        en = 1'b1;
    endtask

    task automatic test_clr_ovf();
        do_reset(); en = 1'b1;
        for (int i = 0; i < 7; i++) pulse_at(16'(2 + 2 * i));
        n_vec++; if (overflow !== 1'b1 || drop_cnt !== 8'd3) begin
            n_err++; $display("FAIL drop3: got o=%b dc=%0d want 1/3", overflow, drop_cnt); end
        advance_to(16'd16);
        pulse_in = 1'b1; clr_ovf = 1'b1; tick(); pulse_in = 1'b0; clr_ovf = 1'b0;
        n_vec++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            n_err++; $display("FAIL clr_vs_drop: got o=%b dc=%0d want 1/1", overflow, drop_cnt); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        n_vec++; if (overflow !== 1'b0 || drop_cnt !== 8'd0 || level !== 3'd4 || rd_data !== 16'd2) begin
            n_err++; $display("FAIL clr_only: got o=%b dc=%0d l=%0d d=%0d want 0/0/4/2",
                              overflow, drop_cnt, level, rd_data); end
        do_reset(); en = 1'b1;
        for (int i = 0; i < 3; i++) pulse_at(16'(2 + 2 * i));
        n_vec++; if (level !== 3'd3) begin
            n_err++; $display("FAIL pre_rst_level: got %0d want 3", level); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_vec++; if (level !== 3'd0 || rd_valid !== 1'b0 || overflow !== 1'b0 || full !== 1'b0) begin
            n_err++; $display("FAIL mid_rst: got l=%0d v=%b o=%b f=%b want 0/0/0/0", level, rd_valid, overflow, full); end
        pulse_in = 1'b1; tick(); pulse_in = 1'b0;
        n_vec++; if (rd_valid !== 1'b1 || level !== 3'd1 || rd_data !== 16'd0) begin
            n_err++; $display("FAIL post_rst_event: got v=%b l=%0d d=%0d want 1/1/0", rd_valid, level, rd_data); end
    endtask

    task automatic test_random();
        logic [29:0] got, want;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) < 8);
            pulse_in = ($urandom_range(0, 9) < 5);
            rd_en    = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 2 : 6));
            clr_ovf  = ($urandom_range(0, 19) == 0);
            tick();
            want = {(m_q.size() > 0) ? m_q[0] : 16'd0, m_q.size() > 0, 3'(m_q.size()),
                    m_q.size() == DEPTH, m_ovf, m_drop};
            got  = {rd_data, rd_valid, level, full, overflow, drop_cnt};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random cyc %0d: got d=%0d v=%b l=%0d f=%b o=%b dc=%0d want d=%0d v=%b l=%0d f=%b o=%b dc=%0d",
                         i, got[29:14], got[13], got[12:10], got[9], got[8], got[7:0],
                         want[29:14], want[13], want[12:10], want[9], want[8], want[7:0]);
            end
        end
        rst = 1'b0; pulse_in = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_held();
        test_overflow();
        test_back_to_back();
        test_wrap();
        test_clr_ovf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
